div32_seq: RTL and testbench

Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, built on iterative restoring subtraction. It sits in the execute stage beside the single-cycle adder/subtractor. The pipeline holds the instruction in EX while `busy` is high and captures `result` on `done`. One operation is in flight at a time, and a flush input lets the hazard unit kill the operation in progress.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/add_sub32.sv | 11 +
 rtl/div32_seq.sv | 187 ++++++++++++++++++
 tb/tb_div32_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 execute-stage definitions: divider op encoding and common constants.
package riscv_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  // DIV and REM treat operands as two's complement; DIVU/REMU as unsigned.
  function automatic logic op_is_signed(input div_op_t o);
    return (o == DIV) || (o == REM);
  endfunction

endpackage

// File: rtl/add_sub32.sv
// Shared 32-bit adder/subtractor used by the execute stage.
module add_sub32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum_c
);

  assign sum_c = sub ? (a - b) : (a + b);

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div32_seq
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(DIV_ITERS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_d, done_d;
  logic [XLEN-1:0] result_d;

  div_op_t         op_e_c;
  logic            signed_op_c, a_neg_c, b_neg_c, ovf_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic [XLEN:0]   shift_c, trial_c;
  logic [XLEN-1:0] quo_neg_c, rem_neg_c;
  logic [XLEN-1:0] quo_fix_c, rem_fix_c;

  // Operand decode for the request presented in IDLE.
  assign op_e_c      = div_op_t'(op);
  assign signed_op_c = op_is_signed(op_e_c);
  assign a_neg_c     = signed_op_c & a[XLEN-1];
  assign b_neg_c     = signed_op_c & b[XLEN-1];
  assign ovf_c       = signed_op_c && (a == INT_MIN) && (b == ALL_ONES);
  assign a_mag_c     = a_neg_c ? ('0 - a) : a;
  assign b_mag_c     = b_neg_c ? ('0 - b) : b;

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign shift_c = {rem_q, dvd_q[XLEN-1]};
  assign trial_c = shift_c - {1'b0, dsr_q};

  add_sub32 u_neg_quo (
    .a     (32'(0)),
    .b     (quo_q),
    .sub   (1'b1),
    .sum_c (quo_neg_c)
  );

  add_sub32 u_neg_rem (
    .a     (32'(0)),
    .b     (rem_q),
    .sub   (1'b1),
    .sum_c (rem_neg_c)
  );

  assign quo_fix_c = neg_quo_q ? quo_neg_c : quo_q;
  assign rem_fix_c = neg_rem_q ? rem_neg_c : rem_q;

  // Next-state and next-datapath logic.
  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    busy_d    = busy;
    done_d    = 1'b0;
    result_d  = result;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          busy_d   = 1'b1;
          is_rem_d = op[1];
          if (b == '0) begin
            // RISC-V divide-by-zero: quotient all ones, remainder is the dividend.
            quo_d     = ALL_ONES;
            rem_d     = a;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIX;
          end else if (ovf_c) begin
            quo_d     = INT_MIN;
            rem_d     = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIX;
          end else begin
            dvd_d     = a_mag_c;
            dsr_d     = b_mag_c;
            neg_quo_d = a_neg_c ^ b_neg_c;
            neg_rem_d = a_neg_c;
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = CNT_W'(DIV_ITERS - 1);
            state_d   = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (!trial_c[XLEN]) begin
            rem_d = trial_c[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shift_c[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!flush) begin
          result_d = is_rem_q ? rem_fix_c : quo_fix_c;
          done_d   = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      result    <= result_d;
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: random and directed RV32M divides against an arithmetic model.
module tb_div32_seq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  div32_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference: RISC-V M-extension semantics using plain SV arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic ovf;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'b01: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b11: return (y == 0) ? x : x % y;
      2'b00: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'($signed(x) / $signed(y));
      end
      default: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        return 32'($signed(x) % $signed(y));
      end
    endcase
  endfunction

  function automatic int unsigned ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      check("busy_low_at_done", 32'(busy), 32'd0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_on_accept", 32'(busy), 32'd1);
    if (track) begin
      e.res = ref_div(o, x, y);
      e.due = cyc + ref_lat(o, x, y);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev;
    logic [31:0] x, y;
    logic [1:0]  o;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    issue(2'b01, 32'd100, 32'd7, 1);
    issue(2'b11, 32'd100, 32'd7, 1);
    issue(2'b00, 32'hFFFF_FFEC, 32'd3, 1);
    issue(2'b10, 32'hFFFF_FFEC, 32'd3, 1);
    issue(2'b01, 32'd5, 32'd0, 1);
    issue(2'b10, 32'hFFFF_FFF1, 32'd0, 1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 1);
    drain();

    // Start while busy must not disturb the running operation.
    issue(2'b01, 32'd100, 32'd7, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Flush mid-CALC.
    prev = result;
    issue(2'b01, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_calc_result", result, prev);

    // Flush while in FIX of a divide-by-zero.
    issue(2'b01, 32'd5, 32'd0, 0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_fix_busy", 32'(busy), 32'd0);
    check("flush_fix_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("flush_fix_result", result, prev);

    // Flush and start together in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);

    issue(2'b01, 32'd9, 32'd2, 1);
    drain();

    // Asynchronous reset mid-operation.
    issue(2'b01, 32'd100, 32'd7, 0);
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b01, 32'd50, 32'd5, 1);
    drain();

    // Randomized back-to-back traffic with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = -32'($urandom_range(1, 15));
        4: x = 32'h8000_0000;
        default: ;
      endcase
      issue(o, x, y, 1);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
